ysyx_22050550_sram_arbiter: RTL and testbench

Two-master, one-slave arbiter placed between the instruction-fetch cache (master 0) and the data cache (master 1) on one side and the DPI-backed SRAM slave on the other. Read and write channels are arbitrated independently with round-robin fairness. A grant is held for the whole burst: for reads until the last R beat, for writes until the AW-declared number of W beats. Payloads are routed without modification, so the SRAM sees a single well-formed AXI-style master.

---
 rtl/ysyx_22050550_sram_arbiter.sv | 170 +++++++++++++++++
 tb/tb_ysyx_22050550_sram_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050550_sram_arbiter.sv
// Two-master round-robin arbiter in front of the SRAM slave; read and write
// channels arbitrate independently and hold the grant for a whole burst.
module ysyx_22050550_sram_arbiter #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [1:0]            m_ar_valid,
   output logic [1:0]            m_ar_ready,
   input  logic [2*ADDR_W-1:0]   m_ar_addr,
   input  logic [15:0]           m_ar_len,
   input  logic [5:0]            m_ar_size,
   input  logic [3:0]            m_ar_burst,
   input  logic [1:0]            m_r_ready,
   output logic [1:0]            m_r_valid,
   output logic [DATA_W-1:0]     m_r_data,
   output logic                  m_r_last,
   input  logic [1:0]            m_aw_valid,
   output logic [1:0]            m_aw_ready,
   input  logic [2*ADDR_W-1:0]   m_aw_addr,
   input  logic [15:0]           m_aw_len,
   input  logic [5:0]            m_aw_size,
   input  logic [3:0]            m_aw_burst,
   input  logic [1:0]            m_w_valid,
   output logic [1:0]            m_w_ready,
   input  logic [2*DATA_W-1:0]   m_w_data,
   input  logic [15:0]           m_w_strb,
   output logic                  s_ar_valid,
   output logic [ADDR_W-1:0]     s_ar_addr,
   output logic [7:0]            s_ar_len,
   output logic [2:0]            s_ar_size,
   output logic [1:0]            s_ar_burst,
   input  logic                  s_ar_ready,
   input  logic                  s_r_valid,
   input  logic [DATA_W-1:0]     s_r_data,
   input  logic                  s_r_last,
   output logic                  s_r_ready,
   output logic                  s_aw_valid,
   output logic [ADDR_W-1:0]     s_aw_addr,
   output logic [7:0]            s_aw_len,
   output logic [2:0]            s_aw_size,
   output logic [1:0]            s_aw_burst,
   input  logic                  s_aw_ready,
   output logic                  s_w_valid,
   output logic [DATA_W-1:0]     s_w_data,
   output logic [7:0]            s_w_strb,
   input  logic                  s_w_ready
);

   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;
   typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA} w_state_e;

   r_state_e   r_state_q, r_state_d;
   w_state_e   w_state_q, w_state_d;
   logic       rg_q, rg_d, r_last_q, r_last_d;
   logic       wg_q, wg_d, w_last_q, w_last_d;
   logic [7:0] wcnt_q, wcnt_d;
   logic [7:0] aw_len_sel;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state_q <= R_IDLE;
         w_state_q <= W_IDLE;
         rg_q      <= 1'b0;
         wg_q      <= 1'b0;
         r_last_q  <= 1'b1;
         w_last_q  <= 1'b1;
         wcnt_q    <= '0;
      end else begin
         r_state_q <= r_state_d;
         w_state_q <= w_state_d;
         rg_q      <= rg_d;
         wg_q      <= wg_d;
         r_last_q  <= r_last_d;
         w_last_q  <= w_last_d;
         wcnt_q    <= wcnt_d;
      end
   end

   // On a tie the master that did not finish the previous burst wins.
   always_comb begin
      r_state_d  = r_state_q;
      rg_d       = rg_q;
      r_last_d   = r_last_q;
      s_ar_valid = 1'b0;
      s_r_ready  = 1'b0;
      m_ar_ready = '0;
      m_r_valid  = '0;
      case (r_state_q)
         R_IDLE: begin
            if (|m_ar_valid) begin
               rg_d      = (&m_ar_valid) ? ~r_last_q : m_ar_valid[1];
               r_state_d = R_ADDR;
            end
         end
         R_ADDR: begin
            s_ar_valid       = m_ar_valid[rg_q];
            m_ar_ready[rg_q] = s_ar_ready;
            if (m_ar_valid[rg_q] && s_ar_ready) r_state_d = R_DATA;
         end
         R_DATA: begin
            m_r_valid[rg_q] = s_r_valid;
            s_r_ready       = m_r_ready[rg_q];
            if (s_r_valid && m_r_ready[rg_q] && s_r_last) begin
               r_state_d = R_IDLE;
               r_last_d  = rg_q;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   assign aw_len_sel = wg_q ? m_aw_len[15:8] : m_aw_len[7:0];

   always_comb begin
      w_state_d  = w_state_q;
      wg_d       = wg_q;
      w_last_d   = w_last_q;
      wcnt_d     = wcnt_q;
      s_aw_valid = 1'b0;
      s_w_valid  = 1'b0;
      m_aw_ready = '0;
      m_w_ready  = '0;
      case (w_state_q)
         W_IDLE: begin
            if (|m_aw_valid) begin
               wg_d      = (&m_aw_valid) ? ~w_last_q : m_aw_valid[1];
               w_state_d = W_ADDR;
            end
         end
         W_ADDR: begin
            s_aw_valid       = m_aw_valid[wg_q];
            m_aw_ready[wg_q] = s_aw_ready;
            if (m_aw_valid[wg_q] && s_aw_ready) begin
               wcnt_d    = aw_len_sel;
               w_state_d = W_DATA;
            end
         end
         W_DATA: begin
            s_w_valid       = m_w_valid[wg_q];
            m_w_ready[wg_q] = s_w_ready;
            if (m_w_valid[wg_q] && s_w_ready) begin
               if (wcnt_q == 8'd0) begin
                  w_state_d = W_IDLE;
                  w_last_d  = wg_q;
               end else begin
                  wcnt_d = wcnt_q - 8'd1;
               end
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // Payloads follow the current grant; forced to zero while reset is low.
   assign s_ar_addr  = !reset ? '0 : (rg_q ? m_ar_addr[2*ADDR_W-1:ADDR_W] : m_ar_addr[ADDR_W-1:0]);
   assign s_ar_len   = !reset ? '0 : (rg_q ? m_ar_len[15:8]  : m_ar_len[7:0]);
   assign s_ar_size  = !reset ? '0 : (rg_q ? m_ar_size[5:3]  : m_ar_size[2:0]);
   assign s_ar_burst = !reset ? '0 : (rg_q ? m_ar_burst[3:2] : m_ar_burst[1:0]);
   assign s_aw_addr  = !reset ? '0 : (wg_q ? m_aw_addr[2*ADDR_W-1:ADDR_W] : m_aw_addr[ADDR_W-1:0]);
   assign s_aw_len   = !reset ? '0 : aw_len_sel;
   assign s_aw_size  = !reset ? '0 : (wg_q ? m_aw_size[5:3]  : m_aw_size[2:0]);
   assign s_aw_burst = !reset ? '0 : (wg_q ? m_aw_burst[3:2] : m_aw_burst[1:0]);
   assign s_w_data   = !reset ? '0 : (wg_q ? m_w_data[2*DATA_W-1:DATA_W] : m_w_data[DATA_W-1:0]);
   assign s_w_strb   = !reset ? '0 : (wg_q ? m_w_strb[15:8] : m_w_strb[7:0]);
   assign m_r_data   = !reset ? '0 : s_r_data;
   assign m_r_last   = reset & s_r_last;

endmodule

// File: tb/tb_ysyx_22050550_sram_arbiter.sv
// Bench for the SRAM arbiter: the bench plays both masters and the SRAM,
// with scoreboard queues for read beats and write beats.
module tb_ysyx_22050550_sram_arbiter;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic [1:0]   m_ar_valid = '0, m_ar_ready;
   logic [127:0] m_ar_addr = '0;
   logic [15:0]  m_ar_len = '0;
   logic [5:0]   m_ar_size = '0;
   logic [3:0]   m_ar_burst = '0;
   logic [1:0]   m_r_ready = '0, m_r_valid;
   logic [63:0]  m_r_data;
   logic         m_r_last;
   logic [1:0]   m_aw_valid = '0, m_aw_ready;
   logic [127:0] m_aw_addr = '0;
   logic [15:0]  m_aw_len = '0;
   logic [5:0]   m_aw_size = '0;
   logic [3:0]   m_aw_burst = '0;
   logic [1:0]   m_w_valid = '0, m_w_ready;
   logic [127:0] m_w_data = '0;
   logic [15:0]  m_w_strb = '0;
   logic         s_ar_valid, s_ar_ready = 1'b0;
   logic [63:0]  s_ar_addr;
   logic [7:0]   s_ar_len;
   logic [2:0]   s_ar_size;
   logic [1:0]   s_ar_burst;
   logic         s_r_valid = 1'b0, s_r_last = 1'b0, s_r_ready;
   logic [63:0]  s_r_data = '0;
   logic         s_aw_valid, s_aw_ready = 1'b0;
   logic [63:0]  s_aw_addr;
   logic [7:0]   s_aw_len;
   logic [2:0]   s_aw_size;
   logic [1:0]   s_aw_burst;
   logic         s_w_valid, s_w_ready = 1'b0;
   logic [63:0]  s_w_data;
   logic [7:0]   s_w_strb;

   ysyx_22050550_sram_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
      .clock(clock), .reset(reset),
      .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
      .m_ar_len(m_ar_len), .m_ar_size(m_ar_size), .m_ar_burst(m_ar_burst),
      .m_r_ready(m_r_ready), .m_r_valid(m_r_valid), .m_r_data(m_r_data), .m_r_last(m_r_last),
      .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_addr(m_aw_addr),
      .m_aw_len(m_aw_len), .m_aw_size(m_aw_size), .m_aw_burst(m_aw_burst),
      .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data), .m_w_strb(m_w_strb),
      .s_ar_valid(s_ar_valid), .s_ar_addr(s_ar_addr), .s_ar_len(s_ar_len),
      .s_ar_size(s_ar_size), .s_ar_burst(s_ar_burst), .s_ar_ready(s_ar_ready),
      .s_r_valid(s_r_valid), .s_r_data(s_r_data), .s_r_last(s_r_last), .s_r_ready(s_r_ready),
      .s_aw_valid(s_aw_valid), .s_aw_addr(s_aw_addr), .s_aw_len(s_aw_len),
      .s_aw_size(s_aw_size), .s_aw_burst(s_aw_burst), .s_aw_ready(s_aw_ready),
      .s_w_valid(s_w_valid), .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_w_ready(s_w_ready)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [63:0] data;
      logic [7:0]  strb;
      logic        last;
   } beat_t;

   typedef struct {
      logic [1:0] req;
      int         exp_g;
      logic [7:0] len;
      int         stall;
   } vec_t;

   beat_t rq[$];
   beat_t wq[$];
   int    n_cmp = 0;
   int    n_err = 0;
   int    cyc = 0;

   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic rd_burst(input int g, input logic [1:0] req, input logic [63:0] a0,
                           input logic [63:0] a1, input logic [7:0] len, input int stall,
                           input int abort_at);
      logic [63:0] ea;
      logic [1:0]  oh;
      beat_t       e, got;
      ea = (g == 1) ? a1 : a0;
      oh = (g == 1) ? 2'b10 : 2'b01;
      m_ar_addr  = {a1, a0};
      m_ar_len   = (g == 1) ? {len, ~len} : {~len, len};
      m_ar_size  = (g == 1) ? {3'd3, 3'd1} : {3'd1, 3'd3};
      m_ar_burst = 4'b0101;
      m_ar_valid = req;
      #1 check("ar_bubble", s_ar_valid, 0);
      tick;
      s_ar_ready = 1'b1;
      #1;
      check("ar_valid", s_ar_valid, 1);
      check("ar_grant", m_ar_ready, oh);
      check("ar_addr", s_ar_addr, ea);
      check("ar_len", s_ar_len, len);
      check("ar_size", s_ar_size, 3);
      tick;
      m_ar_valid = '0;
      s_ar_ready = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         if (b == abort_at) return;
         s_r_valid = 1'b1;
         s_r_data  = ea ^ 64'hA5A5_0000_0000_0000 ^ 64'(b);
         s_r_last  = (b == int'(len));
         e.data = s_r_data;
         e.strb = '0;
         e.last = s_r_last;
         rq.push_back(e);
         for (int s = 0; s < stall && b == 1; s++) begin
            m_r_ready = '0;
            #1;
            check("r_stall_ready", s_r_ready, 0);
            check("r_stall_valid", m_r_valid, oh);
            tick;
         end
         m_r_ready = 2'b11;
         #1;
         check("r_valid", m_r_valid, oh);
         check("r_ready", s_r_ready, 1);
         if (m_r_valid[g] && m_r_ready[g] && rq.size() > 0) begin
            got.data = m_r_data;
            got.last = m_r_last;
            e = rq.pop_front();
            check("r_data", got.data, e.data);
            check("r_last", got.last, e.last);
         end
         tick;
      end
      s_r_valid = 1'b0;
      s_r_last  = 1'b0;
      m_r_ready = '0;
      #1 check("r_idle", {s_ar_valid, m_r_valid, s_r_ready, m_ar_ready}, 0);
   endtask

   task automatic wr_burst(input int g, input logic [1:0] req, input logic [63:0] a0,
                           input logic [63:0] a1, input logic [7:0] len, input int gap);
      logic [63:0] ea, wd;
      logic [1:0]  oh;
      beat_t       e;
      int          hs;
      hs = 0;
      ea = (g == 1) ? a1 : a0;
      oh = (g == 1) ? 2'b10 : 2'b01;
      m_aw_addr  = {a1, a0};
      m_aw_len   = (g == 1) ? {len, ~len} : {~len, len};
      m_aw_size  = (g == 1) ? {3'd3, 3'd2} : {3'd2, 3'd3};
      m_aw_burst = 4'b0101;
      m_aw_valid = req;
      #1 check("aw_bubble", s_aw_valid, 0);
      tick;
      s_aw_ready = 1'b1;
      #1;
      check("aw_valid", s_aw_valid, 1);
      check("aw_grant", m_aw_ready, oh);
      check("aw_addr", s_aw_addr, ea);
      check("aw_len", s_aw_len, len);
      tick;
      m_aw_valid = '0;
      s_aw_ready = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         for (int s = 0; s < gap && b > 0; s++) begin
            m_w_valid = '0;
            s_w_ready = 1'b1;
            #1 check("w_gap", s_w_valid, 0);
            tick;
         end
         wd = ea ^ 64'h5A5A_0000_0000_0000 ^ 64'(b + 1);
         m_w_data  = (g == 1) ? {wd, ~wd} : {~wd, wd};
         m_w_strb  = (g == 1) ? {8'hFF, 8'h0F} : {8'h0F, 8'hFF};
         m_w_valid = 2'b11;
         s_w_ready = 1'b1;
         e.data = wd;
         e.strb = 8'hFF;
         e.last = 1'b0;
         wq.push_back(e);
         #1;
         check("w_grant", m_w_ready, oh);
         if (s_w_valid && s_w_ready && wq.size() > 0) begin
            hs++;
            e = wq.pop_front();
            check("w_data", s_w_data, e.data);
            check("w_strb", s_w_strb, e.strb);
         end
         tick;
      end
      #1;
      check("w_extra_ready", m_w_ready, 0);
      check("w_extra_valid", s_w_valid, 0);
      check("w_beats", hs, int'(len) + 1);
      m_w_valid = '0;
      s_w_ready = 1'b0;
   endtask

   initial begin
      vec_t vt[10];
      int   c0;
      vt[0] = '{2'b01, 0, 8'd3, 0};
      vt[1] = '{2'b11, 1, 8'd0, 0};
      vt[2] = '{2'b11, 0, 8'd2, 3};
      vt[3] = '{2'b11, 1, 8'd1, 0};
      vt[4] = '{2'b11, 0, 8'd0, 0};
      vt[5] = '{2'b10, 1, 8'd0, 0};
      vt[6] = '{2'b10, 1, 8'd1, 0};
      vt[7] = '{2'b11, 0, 8'd0, 0};
      vt[8] = '{2'b01, 0, 8'd0, 0};
      vt[9] = '{2'b11, 1, 8'd1, 0};

      m_ar_addr = {64'h1111, 64'h2222};
      m_w_data  = {64'h3333, 64'h4444};
      m_ar_valid = 2'b11;
      #12;
      check("rst_valids", {s_ar_valid, s_aw_valid, s_w_valid, s_r_ready, m_ar_ready,
                           m_aw_ready, m_w_ready, m_r_valid}, 0);
      check("rst_payload", s_ar_addr | s_w_data, 0);
      m_ar_valid = '0;
      m_ar_addr  = '0;
      reset = 1'b1;
      tick;

      for (int i = 0; i < 10; i++)
         rd_burst(vt[i].exp_g, vt[i].req, 64'h8000_0000 + 64'(i * 64),
                  64'h9000_0000 + 64'(i * 64), vt[i].len, vt[i].stall, -1);

      wr_burst(1, 2'b10, 64'h8000_1000, 64'h9000_1000, 8'd1, 2);
      wr_burst(0, 2'b11, 64'h8000_1100, 64'h9000_1100, 8'd0, 0);
      wr_burst(1, 2'b11, 64'h8000_1200, 64'h9000_1200, 8'd2, 1);
      tick;

      c0 = cyc;
      fork
         rd_burst(0, 2'b01, 64'h8000_2000, 64'h9000_2000, 8'd1, 0, -1);
         wr_burst(1, 2'b10, 64'h8000_3000, 64'h9000_3000, 8'd1, 0);
      join
      check("concurrent_cycles", cyc - c0, 4);
      tick;

      rd_burst(0, 2'b01, 64'h8000_4000, 64'h9000_4000, 8'd0, 0, -1);
      rd_burst(1, 2'b10, 64'h8000_5000, 64'h9000_5000, 8'd3, 0, 1);
      #1 reset = 1'b0;
      #1;
      check("abort_valids", {s_ar_valid, m_ar_ready, m_r_valid, s_r_ready}, 0);
      check("abort_rdata", {m_r_data, m_r_last}, 0);
      check("abort_payload", s_ar_addr, 0);
      s_r_valid = 1'b0;
      s_r_last  = 1'b0;
      m_r_ready = '0;
      rq.delete();
      tick;
      reset = 1'b1;
      tick;
      rd_burst(0, 2'b11, 64'h8000_6000, 64'h9000_6000, 8'd1, 0, -1);
      check("rq_drained", rq.size(), 0);
      check("wq_drained", wq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
